// File: rtl/edge_scan_controller.sv
// Raster-scan sequencer for sobel_processor: steps pixel coordinates in lockstep with
// the processor's 10-cycle period and packs the delayed edge results into BRAM words.
module edge_scan_controller #(
    parameter int IMG_WIDTH     = 1280,
    parameter int IMG_HEIGHT    = 720,
    parameter int ADDR_WIDTH    = 20,
    parameter int SOBEL_PERIOD  = 10,
    parameter int SOBEL_LATENCY = 5,
    parameter int OUT_WORD_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     sobel_reset,
    output logic signed [31:0]       x_center,
    output logic signed [31:0]       y_center,
    input  logic                     edge_detected,
    output logic                     edge_wr_en,
    output logic [ADDR_WIDTH-1:0]    edge_wr_addr,
    output logic [OUT_WORD_BITS-1:0] edge_wr_data,
    output logic [ADDR_WIDTH-1:0]    edge_count
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int BW   = (OUT_WORD_BITS > 1) ? $clog2(OUT_WORD_BITS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]               phase;
    logic [ADDR_WIDTH-1:0]    pix_idx;
    logic [SOBEL_LATENCY-1:0] tag_pipe;
    logic [OUT_WORD_BITS-1:0] pack;
    logic [OUT_WORD_BITS-1:0] pack_set;
    logic [BW-1:0]            bit_pos;
    logic [ADDR_WIDTH-1:0]    word_addr;
    logic [ADDR_WIDTH-1:0]    run_count;
    logic                     calc;
    logic                     pix_last;
    logic                     tag_exit;
    logic                     pipe_empty;
    logic                     abort_now;

    always_comb begin
        calc       = (state == SCAN) && (phase == 4'(SOBEL_PERIOD - 1));
        pix_last   = (pix_idx == ADDR_WIDTH'(NPIX - 1));
        tag_exit   = tag_pipe[SOBEL_LATENCY-1];
        pipe_empty = (tag_pipe == '0);
        abort_now  = abort && ((state == SCAN) || (state == DRAIN));
        pack_set   = pack | (OUT_WORD_BITS'(edge_detected) << bit_pos);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN:  if (abort) state_nxt = IDLE;
                   else if (calc && pix_last) state_nxt = DRAIN;
            DRAIN: if (abort) state_nxt = IDLE;
                   else if (pipe_empty) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            sobel_reset  <= 1'b1;
            x_center     <= '0;
            y_center     <= '0;
            edge_wr_en   <= 1'b0;
            edge_wr_addr <= '0;
            edge_wr_data <= '0;
            edge_count   <= '0;
            phase        <= '0;
            pix_idx      <= '0;
            tag_pipe     <= '0;
            pack         <= '0;
            bit_pos      <= '0;
            word_addr    <= '0;
            run_count    <= '0;
        end else begin
            edge_wr_en <= 1'b0;
            done       <= 1'b0;
            if ((state == IDLE) && start) begin
                busy        <= 1'b1;
                sobel_reset <= 1'b0;
                x_center    <= '0;
                y_center    <= '0;
                phase       <= '0;
                pix_idx     <= '0;
                tag_pipe    <= '0;
                pack        <= '0;
                bit_pos     <= '0;
                word_addr   <= '0;
                run_count   <= '0;
            end else if (abort_now) begin
                // any partially packed word is dropped, not flushed
                busy        <= 1'b0;
                sobel_reset <= 1'b1;
                tag_pipe    <= '0;
                pack        <= '0;
                bit_pos     <= '0;
            end else begin
                if (state == SCAN) begin
                    phase <= calc ? 4'd0 : phase + 4'd1;
                    if (calc) begin
                        if (pix_last) begin
                            sobel_reset <= 1'b1;
                        end else begin
                            pix_idx <= pix_idx + ADDR_WIDTH'(1);
                            if (x_center == IMG_WIDTH - 1) begin
                                x_center <= '0;
                                y_center <= y_center + 32'sd1;
                            end else begin
                                x_center <= x_center + 32'sd1;
                            end
                        end
                    end
                end
                if ((state == SCAN) || (state == DRAIN))
                    tag_pipe <= (tag_pipe << 1) | SOBEL_LATENCY'(calc);
                // results return strictly in pixel order, so position counters replace the tag index
                if (tag_exit) begin
                    run_count <= run_count + ADDR_WIDTH'(edge_detected);
                    if (bit_pos == BW'(OUT_WORD_BITS - 1)) begin
                        edge_wr_en   <= 1'b1;
                        edge_wr_addr <= word_addr;
                        edge_wr_data <= pack_set;
                        word_addr    <= word_addr + ADDR_WIDTH'(1);
                        pack         <= '0;
                        bit_pos      <= '0;
                    end else begin
                        pack    <= pack_set;
                        bit_pos <= bit_pos + BW'(1);
                    end
                end
                if ((state == DRAIN) && pipe_empty) begin
                    done       <= 1'b1;
                    edge_count <= run_count;
                end
                if (state == DONE) busy <= 1'b0;
            end
        end
    end

endmodule
